xnor_gate: RTL and testbench

- Bitwise XNOR function slice of the integer ALU (step-2 logic functions).
- Produces the combinational WIDTH-bit XNOR of operands a and b, plus a registered copy and an equality flag with a valid strobe, for the pipelined ALU result mux.
- Sits beside the and/or/xor slices and feeds the ALU output selector.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/bitwise_reg.sv | 21 ++
 rtl/xnor_gate.sv | 48 ++++
 tb/tb_xnor_gate.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared integer ALU definitions: default datapath width and the
// function-select encoding agreed between the result mux and the slices.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_XNOR = 4'd5,
        ALU_OP_SLL  = 4'd6,
        ALU_OP_SRL  = 4'd7,
        ALU_OP_SRA  = 4'd8,
        ALU_OP_SLT  = 4'd9,
        ALU_OP_SLTU = 4'd10
    } alu_op_e;

    // True for the step-2 bitwise functions that share bitwise_reg.
    function automatic logic is_logic_op(input alu_op_e op);
        return (op == ALU_OP_AND) || (op == ALU_OP_OR) ||
               (op == ALU_OP_XOR) || (op == ALU_OP_XNOR);
    endfunction

endpackage

// File: rtl/bitwise_reg.sv
// Generic enable register with synchronous active-high reset, shared by
// the and/or/xor/xnor ALU slices.
module bitwise_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/xnor_gate.sv
// Bitwise XNOR slice of the integer ALU: combinational result plus a
// registered copy, equality flag and valid strobe for the result mux.
module xnor_gate
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] xnor_out,
    output logic [WIDTH-1:0] xnor_q,
    output logic             eq_q,
    output logic             out_valid
);

    logic [WIDTH:0] cap_d;
    logic [WIDTH:0] cap_q;

    assign xnor_out = ~(a ^ b);

    // Equality flag rides in the top bit of the shared capture register.
    assign cap_d = {&xnor_out, xnor_out};

    bitwise_reg #(
        .WIDTH(WIDTH + 1)
    ) u_cap (
        .clk(clk),
        .rst(rst),
        .en (in_valid),
        .d  (cap_d),
        .q  (cap_q)
    );

    assign xnor_q = cap_q[WIDTH-1:0];
    assign eq_q   = cap_q[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_xnor_gate.sv
// Directed and exhaustive checks of xnor_gate with a scoreboard queue
// holding the expected registered outputs.
module tb_xnor_gate;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic [W-1:0] xnor_out;
    logic [W-1:0] xnor_q;
    logic         eq_q;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] sb[$];
    logic [W-1:0] m_q  = '0;
    logic         m_eq = 1'b0;

    always #5 clk = ~clk;

    xnor_gate #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .xnor_out (xnor_out),
        .xnor_q   (xnor_q),
        .eq_q     (eq_q),
        .out_valid(out_valid)
    );

    task automatic step(input logic r, input logic v,
                        input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] exp_comb, input string tag);
        logic [W+1:0] e;
        logic         e_val;
        @(negedge clk);
        rst = r;
        in_valid = v;
        a = ta;
        b = tb;
        #1;
        checks++;
        assert (xnor_out === exp_comb) else begin
            errors++;
            $error("FAIL %s xnor_out got %b want %b", tag, xnor_out, exp_comb);
        end
        if (r) begin
            m_q = '0;
            m_eq = 1'b0;
            e_val = 1'b0;
        end else if (v) begin
            m_q = exp_comb;
            m_eq = (exp_comb == {W{1'b1}});
            e_val = 1'b1;
        end else begin
            e_val = 1'b0;
        end
        sb.push_back({m_eq, e_val, m_q});
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty got %0d want >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (xnor_q === e[W-1:0]) else begin
                errors++;
                $error("FAIL %s xnor_q got %b want %b", tag, xnor_q, e[W-1:0]);
            end
            checks++;
            assert (out_valid === e[W]) else begin
                errors++;
                $error("FAIL %s out_valid got %b want %b", tag, out_valid, e[W]);
            end
            checks++;
            assert (eq_q === e[W+1]) else begin
                errors++;
                $error("FAIL %s eq_q got %b want %b", tag, eq_q, e[W+1]);
            end
        end
    endtask

    initial begin
        logic [W-1:0] sa;
        logic [W-1:0] sbv;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;

        step(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, "reset_idle");
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, "zeros");
        step(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0001, "f_vs_1");
        step(1'b0, 1'b1, 4'b1010, 4'b1100, 4'b1001, "a_vs_c");
        step(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, "ones");
        step(1'b0, 1'b0, 4'b0101, 4'b1010, 4'b0000, "hold_inv");
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, "hold_again");
        step(1'b0, 1'b1, 4'b0110, 4'b1001, 4'b0000, "inverse");
        step(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b1111, "reset_wins");
        step(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b1111, "post_reset");
        step(1'b1, 1'b0, 4'b0100, 4'b0010, 4'b1001, "mid_reset");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = 4'(i);
                sbv = 4'(j);
                step(1'b0, 1'b1, sa, sbv, ~(sa ^ sbv), "sweep");
            end
        end

        step(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b1111, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
